pe_array_ctrl: RTL
==================

// Module: pe_array_ctrl
// PURPOSE
//  Sequencer for a ROWS x COLS systolic array of packed-16b MAC PEs (2-bit mode: DISABLE/SINGLE/CLEAR).
//  On start: clears all accumulators, drives skewed per-PE SINGLE windows and row/col feed enables,
//  then drains results one row per cycle and pulses done. Sits between the CNN command regs and the PE array.
// PARAMETERS
//  ROWS  4  PE rows (data injected on left edge, one stream per row)
//  COLS  4  PE columns (weights injected on top edge, one stream per column)
//  K_W   8  width of k_len; max accumulation depth 2^K_W-1 packed pairs
// PORTS
//  clk          in   1             clock
//  rst_n        in   1             asynchronous, active-low reset
//  start        in   1             launch op; sampled only in IDLE
//  abort        in   1             cancel op; return to IDLE next cycle
//  k_len        in   K_W           packed-pair steps per dot product; sampled with start
//  busy         out  1             high from cycle after start through DONE
//  done         out  1             one-cycle pulse at end of drain
//  mode_o       out  2*ROWS*COLS   PE(i,j) mode at bits [2*(i*COLS+j)+:2]
//  row_feed_en  out  ROWS          row i buffer must present next element this cycle
//  col_feed_en  out  COLS          col j buffer must present next element this cycle
//  res_valid    out  1             result row selected this cycle
//  res_row_sel  out  $clog2(ROWS)  row index being drained
// BEHAVIOUR
//  Reset: state IDLE, mode_o all DISABLE (2'b00), every other output 0. All outputs registered.
//  FSM: IDLE -start-> CLR (1 cycle) -> COMP (T = K+ROWS+COLS-2 cycles, t=0..T-1) -> DRAIN (ROWS cycles) -> DONE (1) -> IDLE.
//  CLR: mode_o all CLEAR. COMP: PE(i,j) SINGLE iff i+j <= t < i+j+K, else DISABLE.
//  row_feed_en[i] high iff COMP and i <= t < i+K; col_feed_en[j] iff COMP and j <= t < j+K (skew = index).
//  DRAIN: mode_o all DISABLE (results hold); res_valid=1, res_row_sel = 0..ROWS-1 ascending.
//  DONE: done=1, busy=1; busy drops on return to IDLE. Total busy cycles = T+ROWS+2.
//  k_len==0: CLR -> DRAIN directly (COMP skipped), results read as 0.
//  start while not IDLE: ignored. abort in any non-IDLE state: next cycle IDLE, mode_o all DISABLE,
//   feeds/res_valid 0, no done pulse; abort has priority over state advance; abort and start same cycle in IDLE: start wins... abort ignored in IDLE.
//  rst_n mid-op: immediate return to reset values; PE accumulators are cleared by their own reset.
//  t counter width K_W+$clog2(ROWS+COLS)+1; no wrap within legal k_len.
// CONFIGURATION
//  PE_CTRL_PERF_EN defined: extra output perf_cycles[31:0], counts busy cycles of the current op,
//   cleared on start, holds final value after DONE/abort, saturates at 32'hFFFF_FFFF.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Shared header cnn_pe_defines.vh: PE_DISABLE=2'b00, PE_SINGLE=2'b01, PE_CLEAR=2'b10 (shared with PE),
//   FSM state encodings for pe_array_ctrl.
//  One sub-module: pe_ctrl_window (generate per PE and per edge feed): given t, offset, K -> in-window flag.
//  Top holds FSM, t counter, drain counter, output registers.
// TESTING
//  Reset: rst_n low -> mode_o=0, busy=0, done=0, feeds=0, res_valid=0.
//  ROWS=COLS=4, k_len=3, start pulse -> 1 CLR cycle, COMP 9 cycles, PE(3,3) SINGLE at t=6..8, busy 15 cycles, done once.
//  Same, with bench PE model and A=I, B=known -> drained rows res_row_sel 0..3 match reference matmul.
//  k_len=0 -> CLR then DRAIN immediately, busy 6 cycles, done pulse, no SINGLE ever on mode_o.
//  abort at COMP t=4 -> next cycle IDLE, all DISABLE, no done; start again with k_len=2 completes normally.
//  start reasserted during COMP -> ignored, op length unchanged; PE_CTRL_PERF_EN build: perf_cycles=15 for k_len=3.

Source files
------------

// File: rtl/pe_array_ctrl_pkg.sv
// Shared PE mode encodings and sequencer state encodings for the
// systolic array controller and its PEs.
package pe_array_ctrl_pkg;

    localparam logic [1:0] PE_DISABLE = 2'b00;
    localparam logic [1:0] PE_SINGLE  = 2'b01;
    localparam logic [1:0] PE_CLEAR   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_COMP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/pe_array_ctrl_window.sv
// Skewed activity window: hit while off <= t < off + k.
module pe_ctrl_window #(
    parameter int TW = 12
) (
    input  logic [TW-1:0] t,
    input  logic [TW-1:0] off,
    input  logic [TW-1:0] k,
    output logic          hit
);

    assign hit = (t >= off) && (t < off + k);

endmodule

// File: rtl/pe_array_ctrl.sv
// Systolic array sequencer: clear, skewed compute windows, row drain.
// Optional PE_CTRL_PERF_EN adds a saturating busy-cycle counter.
module pe_array_ctrl
    import pe_array_ctrl_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int K_W  = 8,
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [K_W-1:0]         k_len,
    output logic                   busy,
    output logic                   done,
    output logic [2*ROWS*COLS-1:0] mode_o,
    output logic [ROWS-1:0]        row_feed_en,
    output logic [COLS-1:0]        col_feed_en,
    output logic                   res_valid,
`ifdef PE_CTRL_PERF_EN
    output logic [RW-1:0]          res_row_sel,
    output logic [31:0]            perf_cycles
`else
    output logic [RW-1:0]          res_row_sel
`endif
);

    localparam int TW = K_W + $clog2(ROWS + COLS) + 1;
    localparam int NPE = ROWS * COLS;

    state_e state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic [TW-1:0] k_q, k_d;
    logic [RW-1:0] row_q, row_d;
    logic [TW-1:0] t_last;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic res_valid_q, res_valid_d;
    logic [RW-1:0] res_row_sel_q, res_row_sel_d;
    logic [2*NPE-1:0] mode_q, mode_d;
    logic [ROWS-1:0] row_feed_q, row_feed_d;
    logic [COLS-1:0] col_feed_q, col_feed_d;

    logic [NPE-1:0] pe_hit;
    logic [ROWS-1:0] row_hit;
    logic [COLS-1:0] col_hit;

    assign t_last = k_q + TW'(ROWS + COLS - 3);

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        k_d     = k_q;
        row_d   = row_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLR;
                    k_d     = TW'(k_len);
                    t_d     = '0;
                    row_d   = '0;
                end
            end
            ST_CLR: begin
                state_d = (k_q == '0) ? ST_DRAIN : ST_COMP;
                t_d     = '0;
                row_d   = '0;
            end
            ST_COMP: begin
                if (t_q == t_last) state_d = ST_DRAIN;
                else               t_d     = t_q + 1'b1;
            end
            ST_DRAIN: begin
                if (row_q == RW'(ROWS - 1)) state_d = ST_DONE;
                else                        row_d   = row_q + 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // abort outranks any advance, but IDLE ignores it
        if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        pe_ctrl_window #(.TW(TW)) u_row (
            .t   (t_d),
            .off (TW'(i)),
            .k   (k_q),
            .hit (row_hit[i])
        );
        for (genvar j = 0; j < COLS; j++) begin : g_pe
            pe_ctrl_window #(.TW(TW)) u_pe (
                .t   (t_d),
                .off (TW'(i + j)),
                .k   (k_q),
                .hit (pe_hit[i*COLS+j])
            );
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_col
        pe_ctrl_window #(.TW(TW)) u_col (
            .t   (t_d),
            .off (TW'(j)),
            .k   (k_q),
            .hit (col_hit[j])
        );
    end

    // outputs are registered from next-state values so they align with state
    always_comb begin
        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_d == ST_DONE);
        res_valid_d   = (state_d == ST_DRAIN);
        res_row_sel_d = (state_d == ST_DRAIN) ? row_d : '0;
        mode_d        = '0;
        row_feed_d    = '0;
        col_feed_d    = '0;
        unique case (state_d)
            ST_CLR: begin
                for (int p = 0; p < NPE; p++) mode_d[2*p+:2] = PE_CLEAR;
            end
            ST_COMP: begin
                for (int p = 0; p < NPE; p++)
                    mode_d[2*p+:2] = pe_hit[p] ? PE_SINGLE : PE_DISABLE;
                row_feed_d = row_hit;
                col_feed_d = col_hit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            t_q           <= '0;
            k_q           <= '0;
            row_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            res_valid_q   <= 1'b0;
            res_row_sel_q <= '0;
            mode_q        <= '0;
            row_feed_q    <= '0;
            col_feed_q    <= '0;
        end else begin
            state_q       <= state_d;
            t_q           <= t_d;
            k_q           <= k_d;
            row_q         <= row_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            res_valid_q   <= res_valid_d;
            res_row_sel_q <= res_row_sel_d;
            mode_q        <= mode_d;
            row_feed_q    <= row_feed_d;
            col_feed_q    <= col_feed_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign res_valid   = res_valid_q;
    assign res_row_sel = res_row_sel_q;
    assign mode_o      = mode_q;
    assign row_feed_en = row_feed_q;
    assign col_feed_en = col_feed_q;

`ifdef PE_CTRL_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == ST_IDLE && start)   perf_d = '0;
        else if (busy_q && perf_q != '1)   perf_d = perf_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`endif

endmodule
